// File: rtl/bus_response_mux.sv
// bus_response_mux: CPU data-bus return path; gates decoded requests, tracks in-order outstanding
// transactions to one target at a time, and routes acks/read data or synthesised errors. Optional timeout: BUS_TIMEOUT_EN.
module bus_response_mux #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic        dec_dmem_request,
    input  logic        dec_hwregs_request,
    input  logic        dec_patmem_request,
    input  logic        dec_imem_request,
    input  logic        dec_error_request,
    output logic        dmem_request,
    output logic        hwregs_request,
    output logic        patmem_request,
    output logic        imem_request,
    input  logic        dmem_ack,
    input  logic        hwregs_ack,
    input  logic        patmem_ack,
    input  logic        imem_ack,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] hwregs_rdata,
    input  logic [31:0] patmem_rdata,
    input  logic [31:0] imem_rdata,
    output logic        cpu_stall,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_error,
    output logic [31:0] error_address,
    output logic        spurious_ack
);
    typedef enum logic [2:0] {T_NONE, T_DMEM, T_HWREGS, T_PATMEM, T_IMEM, T_ERROR} tgt_t;

    tgt_t        r_tgt;
    tgt_t        w_req_tgt;
    logic [3:0]  r_cnt;
    logic        r_err_pending;
    logic        w_any_dec;
    logic        w_busy;
    logic        w_accept;
    logic        w_tgt_ack;
    logic        w_sel_ack;
    logic        w_timeout;
    logic        w_done;
    logic        w_err_resp;
    logic        w_spur;
    logic [31:0] w_tgt_rdata;

    assign w_req_tgt = dec_dmem_request   ? T_DMEM   :
                       dec_hwregs_request ? T_HWREGS :
                       dec_patmem_request ? T_PATMEM :
                       dec_imem_request   ? T_IMEM   :
                       dec_error_request  ? T_ERROR  : T_NONE;
    assign w_any_dec = dec_dmem_request | dec_hwregs_request | dec_patmem_request |
                       dec_imem_request | dec_error_request;
    assign w_busy    = r_cnt != 4'd0;
    assign cpu_stall = w_any_dec & ((r_cnt == 4'(MAX_OUTSTANDING)) | (w_busy & (w_req_tgt != r_tgt)));
    assign w_accept  = w_any_dec & ~cpu_stall;

    assign dmem_request   = dec_dmem_request & ~cpu_stall;
    assign hwregs_request = dec_hwregs_request & ~cpu_stall;
    assign patmem_request = dec_patmem_request & ~cpu_stall;
    assign imem_request   = dec_imem_request & ~cpu_stall;

    assign w_tgt_ack = (r_tgt == T_DMEM)   ? dmem_ack      :
                       (r_tgt == T_HWREGS) ? hwregs_ack    :
                       (r_tgt == T_PATMEM) ? patmem_ack    :
                       (r_tgt == T_IMEM)   ? imem_ack      :
                       (r_tgt == T_ERROR)  ? r_err_pending : 1'b0;
    assign w_tgt_rdata = (r_tgt == T_DMEM)   ? dmem_rdata   :
                         (r_tgt == T_HWREGS) ? hwregs_rdata :
                         (r_tgt == T_PATMEM) ? patmem_rdata :
                         (r_tgt == T_IMEM)   ? imem_rdata   : 32'd0;
    assign w_sel_ack = w_busy & w_tgt_ack;

    // any slave ack not belonging to the live target is flagged and otherwise ignored
    assign w_spur = (dmem_ack   & (~w_busy | (r_tgt != T_DMEM)))   |
                    (hwregs_ack & (~w_busy | (r_tgt != T_HWREGS))) |
                    (patmem_ack & (~w_busy | (r_tgt != T_PATMEM))) |
                    (imem_ack   & (~w_busy | (r_tgt != T_IMEM)));

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;
    assign w_timeout = w_busy & ~w_sel_ack & (r_timer == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_timer <= '0;
        else if (w_accept | w_sel_ack | w_timeout)
            r_timer <= '0;
        else if (w_busy)
            r_timer <= r_timer + 1'b1;
    end
`else
    assign w_timeout = TIMEOUT_CYCLES < 0;
`endif

    assign w_done     = w_sel_ack | w_timeout;
    assign w_err_resp = w_timeout | (r_tgt == T_ERROR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt         <= 4'd0;
            r_tgt         <= T_NONE;
            r_err_pending <= 1'b0;
            cpu_ack       <= 1'b0;
            cpu_error     <= 1'b0;
            cpu_rdata     <= 32'd0;
            error_address <= 32'd0;
            spurious_ack  <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + 4'(w_accept) - 4'(w_done);
            r_err_pending <= w_accept & dec_error_request;
            cpu_ack       <= w_done;
            cpu_error     <= w_done & w_err_resp;
            spurious_ack  <= spurious_ack | w_spur;
            if (w_accept)
                r_tgt <= w_req_tgt;
            if (w_accept & dec_error_request)
                error_address <= cpu_address;
            if (w_done)
                cpu_rdata <= w_err_resp ? 32'd0 : w_tgt_rdata;
        end
    end
endmodule

// File: tb/tb_bus_response_mux.sv
// tb_bus_response_mux: directed bench with a response scoreboard for bus_response_mux.
module tb_bus_response_mux;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_address = '0;
    logic        dec_dmem_request = 0, dec_hwregs_request = 0, dec_patmem_request = 0;
    logic        dec_imem_request = 0, dec_error_request = 0;
    logic        dmem_request, hwregs_request, patmem_request, imem_request;
    logic        dmem_ack = 0, hwregs_ack = 0, patmem_ack = 0, imem_ack = 0;
    logic [31:0] dmem_rdata = '0, hwregs_rdata = '0, patmem_rdata = '0, imem_rdata = '0;
    logic        cpu_stall, cpu_ack, cpu_error, spurious_ack;
    logic [31:0] cpu_rdata, error_address;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;
    rsp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bus_response_mux #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .cpu_address(cpu_address),
        .dec_dmem_request(dec_dmem_request), .dec_hwregs_request(dec_hwregs_request),
        .dec_patmem_request(dec_patmem_request), .dec_imem_request(dec_imem_request),
        .dec_error_request(dec_error_request),
        .dmem_request(dmem_request), .hwregs_request(hwregs_request),
        .patmem_request(patmem_request), .imem_request(imem_request),
        .dmem_ack(dmem_ack), .hwregs_ack(hwregs_ack), .patmem_ack(patmem_ack), .imem_ack(imem_ack),
        .dmem_rdata(dmem_rdata), .hwregs_rdata(hwregs_rdata),
        .patmem_rdata(patmem_rdata), .imem_rdata(imem_rdata),
        .cpu_stall(cpu_stall), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_error(cpu_error),
        .error_address(error_address), .spurious_ack(spurious_ack)
    );

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic err, input logic [31:0] data);
        sb.push_back('{err: err, data: data});
    endtask

    task automatic resp(input string tag);
        rsp_t e;
        e = (sb.size() != 0) ? sb.pop_front() : 'x;
        chk({tag, "_ack"}, cpu_ack, 1);
        chk({tag, "_err"}, cpu_error, e.err);
        chk({tag, "_data"}, cpu_rdata, e.data);
    endtask

    initial begin
        smp();
        chk("rst_ack", cpu_ack, 0);
        chk("rst_err", cpu_error, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_eaddr", error_address, 0);
        chk("rst_spur", spurious_ack, 0);
        nxt();
        reset = 0;

        // single dmem read, ack three cycles after acceptance
        dec_dmem_request = 1;
        smp();
        chk("t1_stall", cpu_stall, 0);
        chk("t1_req", dmem_request, 1);
        nxt(); dec_dmem_request = 0;
        nxt();
        nxt();
        dmem_ack = 1; dmem_rdata = 32'h12345678; push(0, 32'h12345678);
        smp();
        chk("t1_noack", cpu_ack, 0);
        nxt(); dmem_ack = 0; dmem_rdata = 32'hdeadbeef;
        smp();
        resp("t1");
        nxt(); dec_hwregs_request = 1;
        smp();
        chk("t1_hold", cpu_rdata, 32'h12345678);
        chk("t1_ackclr", cpu_ack, 0);
        chk("t1_idle", cpu_stall, 0);
        nxt(); dec_hwregs_request = 0; hwregs_ack = 1; hwregs_rdata = 32'ha5a50001; push(0, 32'ha5a50001);
        nxt(); hwregs_ack = 0;
        smp();
        resp("t1b");
        chk("t1_nospur", spurious_ack, 0);

        // target switch held off until the dmem requests drain
        nxt(); dec_dmem_request = 1;
        smp(); chk("t2_acc1", cpu_stall, 0);
        nxt();
        smp(); chk("t2_acc2", cpu_stall, 0);
        nxt(); dec_dmem_request = 0; dec_hwregs_request = 1;
        smp();
        chk("t2_stall", cpu_stall, 1);
        chk("t2_gate", hwregs_request, 0);
        nxt(); dmem_ack = 1; dmem_rdata = 32'h11111111; push(0, 32'h11111111);
        smp(); chk("t2_stall2", cpu_stall, 1);
        nxt(); dmem_ack = 0;
        smp(); resp("t2a"); chk("t2_stall3", cpu_stall, 1);
        nxt(); dmem_ack = 1; dmem_rdata = 32'h22222222; push(0, 32'h22222222);
        smp(); chk("t2_stall4", cpu_stall, 1);
        nxt(); dmem_ack = 0;
        smp();
        resp("t2b");
        chk("t2_go", cpu_stall, 0);
        chk("t2_req", hwregs_request, 1);
        nxt(); dec_hwregs_request = 0; hwregs_ack = 1; hwregs_rdata = 32'h33333333; push(0, 32'h33333333);
        nxt(); hwregs_ack = 0;
        smp(); resp("t2c");

        // fill to MAX_OUTSTANDING with imem requests
        nxt(); dec_imem_request = 1;
        for (int i = 0; i < 4; i++) begin
            smp(); chk($sformatf("t3_acc%0d", i), cpu_stall, 0);
            nxt();
        end
        smp();
        chk("t3_full", cpu_stall, 1);
        chk("t3_gate", imem_request, 0);
        nxt(); imem_ack = 1; imem_rdata = 32'h40000000; push(0, 32'h40000000);
        smp(); chk("t3_fullack", cpu_stall, 1);
        nxt(); imem_ack = 0;
        smp();
        resp("t3a");
        chk("t3_refill", cpu_stall, 0);
        chk("t3_req", imem_request, 1);
        nxt();
        smp(); chk("t3_full2", cpu_stall, 1);
        nxt(); dec_imem_request = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                imem_ack = 1; imem_rdata = 32'h40000001 + i; push(0, 32'h40000001 + i);
            end else imem_ack = 0;
            smp();
            if (i > 0) resp($sformatf("t3d%0d", i));
            nxt();
        end

        // error requests: single, then back-to-back
        dec_error_request = 1; cpu_address = 32'h80000000; push(1, 0);
        smp(); chk("t4_stall", cpu_stall, 0);
        nxt(); dec_error_request = 0; cpu_address = 0;
        smp();
        chk("t4_noack", cpu_ack, 0);
        chk("t4_eaddr", error_address, 32'h80000000);
        nxt();
        smp(); resp("t4a");
        nxt(); dec_error_request = 1; cpu_address = 32'h80000004; push(1, 0);
        smp(); chk("t4_b2b_stall", cpu_stall, 0);
        nxt(); cpu_address = 32'h80000008; push(1, 0);
        smp();
        chk("t4_eaddr2", error_address, 32'h80000004);
        chk("t4_noack2", cpu_ack, 0);
        nxt(); dec_error_request = 0; cpu_address = 0;
        smp(); resp("t4b"); chk("t4_eaddr3", error_address, 32'h80000008);
        nxt();
        smp(); resp("t4c");

        // spurious acks
        nxt(); hwregs_ack = 1;
        smp(); chk("t5_pre", spurious_ack, 0);
        nxt(); hwregs_ack = 0;
        smp();
        chk("t5_spur", spurious_ack, 1);
        chk("t5_noack", cpu_ack, 0);
        nxt();
        nxt();
        smp(); chk("t5_sticky", spurious_ack, 1);
        nxt(); reset = 1;
        smp();
        chk("t5_rst", spurious_ack, 0);
        chk("t5_rst_eaddr", error_address, 0);
        nxt(); reset = 0; dec_dmem_request = 1;
        nxt(); dec_dmem_request = 0; patmem_ack = 1;
        nxt(); patmem_ack = 0; dmem_ack = 1; dmem_rdata = 32'h55555555; push(0, 32'h55555555);
        smp();
        chk("t5_nontgt", spurious_ack, 1);
        chk("t5_noack2", cpu_ack, 0);
        nxt(); dmem_ack = 0; dec_hwregs_request = 1;
        smp();
        resp("t5");
        chk("t5_cnt0", cpu_stall, 0);
        nxt(); dec_hwregs_request = 0; reset = 1;
        nxt(); reset = 0; hwregs_ack = 1;
        nxt(); hwregs_ack = 0;
        smp();
        chk("t5_late", spurious_ack, 1);
        chk("t5_late_noack", cpu_ack, 0);

`ifdef BUS_TIMEOUT_EN
        nxt(); dec_patmem_request = 1; push(1, 0);
        smp(); chk("t6_stall", cpu_stall, 0);
        nxt(); dec_patmem_request = 0;
        for (int k = 1; k <= 8; k++) begin
            smp(); chk($sformatf("t6_wait%0d", k), cpu_ack, 0);
            nxt();
        end
        smp();
        resp("t6");
        chk("t6_eaddr", error_address, 0);
        nxt(); dec_hwregs_request = 1;
        smp(); chk("t6_cnt0", cpu_stall, 0);
        nxt(); dec_hwregs_request = 0; hwregs_ack = 1; hwregs_rdata = 32'h66666666; push(0, 32'h66666666);
        nxt(); hwregs_ack = 0;
        smp(); resp("t6b");
`endif

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
